heater_control: RTL and testbench

- Downstream consumer of the thermistor ADC-to-temperature stage.
- Takes a signed whole-degree temperature sample and a target temperature. Produces a glitch-free PWM drive for one heater (hotend or bed) from a saturated proportional law.
- Adds safety supervision: over-temperature, sensor open/short and thermal runaway. The resulting fault is latched and reported to the printer control logic.

---
 rtl/heater_control.sv | 177 +++++++++++++++++
 tb/tb_heater_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/heater_control.sv
// Heater regulator: proportional PWM drive with latched over-temp, sensor and
// thermal-runaway supervision.
//
//   state | meaning
//   IDLE  | heater off, waiting for enable
//   HEAT  | regulating, faults checked on every temperature strobe
//   FAULT | heater off, fault latched until enable drops
module heater_control #(
  parameter int CLK_FREQ      = 50000000,
  parameter int PWM_DIV       = 195,
  parameter int KP            = 16,
  parameter int MAX_TEMP      = 280,
  parameter int WINDOW        = 3,
  parameter int RUNAWAY_S     = 20,
  parameter int RUNAWAY_DELTA = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [11:0] target,
  input  logic signed [11:0] temp,
  input  logic               temp_valid,
  output logic               heater,
  output logic [7:0]         duty,
  output logic               at_target,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int SW = $clog2(RUNAWAY_S + 1);
  localparam logic [TW-1:0]        TICK_LOAD = TW'(CLK_FREQ - 1);
  localparam logic [DW-1:0]        DIV_LOAD  = DW'(PWM_DIV - 1);
  localparam logic [SW-1:0]        SEC_LIMIT = SW'(RUNAWAY_S);
  localparam logic signed [12:0]   MAX_T     = 13'(MAX_TEMP);
  localparam logic signed [12:0]   WIN       = 13'(WINDOW);
  localparam logic signed [12:0]   DELTA     = 13'(RUNAWAY_DELTA);
  localparam logic signed [20:0]   KP21      = 21'(KP);
  localparam logic signed [11:0]   SENS_HI   = 12'sd300;
  localparam logic signed [11:0]   SENS_LO   = -12'sd55;

  typedef enum logic [1:0] {IDLE, HEAT, FAULT} state_t;
  state_t state, state_nxt;

  logic [1:0]         code_nxt;
  logic [DW-1:0]      div_cnt, div_nxt;
  logic [7:0]         pwm_cnt, cnt_nxt;
  logic [7:0]         duty_q, duty_nxt, duty_req, duty_calc;
  logic               heater_q, heater_nxt, at_q;
  logic [TW-1:0]      tick_cnt;
  logic               tick, div_tc, wrap;
  logic signed [11:0] temp_q, ref_t, sample;
  logic [SW-1:0]      sec_cnt;
  logic               rt_active, heat_full;
  logic signed [12:0] tgt13, t_eff, temp13, err, ref13;
  logic signed [20:0] err21, prod;
  logic               at_cond, sensor_f, over_f, runaway_f;

  // Control law, evaluated on the raw sample of the strobe cycle
  always_comb begin
    tgt13  = {target[11], target};
    temp13 = {temp[11], temp};
    ref13  = {ref_t[11], ref_t};
    if (tgt13 < 13'sd0)     t_eff = 13'sd0;
    else if (tgt13 > MAX_T) t_eff = MAX_T;
    else                    t_eff = tgt13;
    err   = t_eff - temp13;
    err21 = err;
    prod  = err21 * KP21;
    if (err <= 13'sd0)        duty_calc = 8'd0;
    else if (prod > 21'sd255) duty_calc = 8'd255;
    else                      duty_calc = prod[7:0];
    at_cond   = (err <= WIN) && (err >= -WIN);
    sensor_f  = (temp >= SENS_HI) || (temp <= SENS_LO);
    over_f    = temp13 > MAX_T;
    runaway_f = sec_cnt >= SEC_LIMIT;
    sample    = temp_valid ? temp : temp_q;
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = fault_code;
    case (state)
      IDLE: begin
        code_nxt = 2'd0;
        if (enable) state_nxt = HEAT;
      end
      HEAT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (temp_valid && (sensor_f || over_f || runaway_f)) begin
          state_nxt = FAULT;
          if (sensor_f)    code_nxt = 2'd3;
          else if (over_f) code_nxt = 2'd1;
          else             code_nxt = 2'd2;
        end
      end
      FAULT: begin
        if (!enable) begin
          state_nxt = IDLE;
          code_nxt  = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        code_nxt  = 2'd0;
      end
    endcase
  end

  // PWM: duty only reloads at the period boundary; leaving HEAT kills it at once
  always_comb begin
    tick    = (tick_cnt == '0);
    div_tc  = (div_cnt == '0);
    div_nxt = div_tc ? DIV_LOAD : div_cnt - DW'(1);
    cnt_nxt = div_tc ? pwm_cnt + 8'd1 : pwm_cnt;
    wrap    = div_tc && (pwm_cnt == 8'd255);
    if (state_nxt != HEAT) duty_nxt = 8'd0;
    else if (wrap)         duty_nxt = duty_req;
    else                   duty_nxt = duty_q;
    heater_nxt = (state_nxt == HEAT) && ((cnt_nxt < duty_nxt) || (duty_nxt == 8'd255));
    heat_full  = (state == HEAT) && (duty_q == 8'd255);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fault_code <= 2'd0;
      div_cnt    <= DIV_LOAD;
      pwm_cnt    <= 8'd0;
      duty_q     <= 8'd0;
      duty_req   <= 8'd0;
      heater_q   <= 1'b0;
      at_q       <= 1'b0;
      tick_cnt   <= TICK_LOAD;
      temp_q     <= 12'sd0;
      ref_t      <= 12'sd0;
      sec_cnt    <= '0;
      rt_active  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fault_code <= code_nxt;
      div_cnt    <= div_nxt;
      pwm_cnt    <= cnt_nxt;
      duty_q     <= duty_nxt;
      heater_q   <= heater_nxt;
      tick_cnt   <= tick ? TICK_LOAD : tick_cnt - TW'(1);
      if (temp_valid) begin
        temp_q   <= temp;
        duty_req <= duty_calc;
      end
      if (state_nxt != HEAT) at_q <= 1'b0;
      else if (temp_valid)   at_q <= at_cond;
      // Runaway timer only runs while the heater is pinned at full duty
      if (!heat_full) begin
        rt_active <= 1'b0;
        sec_cnt   <= '0;
      end else if (!rt_active) begin
        rt_active <= 1'b1;
        ref_t     <= sample;
        sec_cnt   <= '0;
      end else if (temp_valid && (temp13 >= ref13 + DELTA)) begin
        ref_t   <= temp;
        sec_cnt <= '0;
      end else if (tick && (sec_cnt < SEC_LIMIT)) begin
        sec_cnt <= sec_cnt + SW'(1);
      end
    end
  end

  assign heater    = heater_q;
  assign duty      = duty_q;
  assign at_target = at_q;
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_heater_control.sv
// Directed bench for heater_control: duty law, PWM period behaviour and fault
// supervision, with a fast tick and short PWM step.
module tb_heater_control;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic signed [11:0] target;
  logic signed [11:0] temp;
  logic              temp_valid;
  logic              heater;
  logic [7:0]        duty;
  logic              at_target;
  logic              fault;
  logic [1:0]        fault_code;

  int checks   = 0;
  int failures = 0;

  heater_control #(
    .CLK_FREQ(1000), .PWM_DIV(2), .KP(16), .MAX_TEMP(280),
    .WINDOW(3), .RUNAWAY_S(3), .RUNAWAY_DELTA(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .temp(temp), .temp_valid(temp_valid), .heater(heater), .duty(duty),
    .at_target(at_target), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int t);
    temp = 12'(t);
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  task automatic wait_duty(input logic [7:0] exp, input string tag);
    int n = 0;
    while (duty !== exp && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(duty), 32'(exp));
  endtask

  task automatic count_heater(input int cycles, output int high);
    high = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (heater === 1'b1) high++;
    end
  endtask

  task automatic clear_fault();
    enable = 1'b0;
    @(negedge clk);
    chk("clear_fault", 32'(fault), 32'd0);
    chk("clear_code", 32'(fault_code), 32'd0);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int high;
    int n;
    int cur;
    reset = 1'b0; enable = 1'b0; target = 12'sd0; temp = 12'sd0; temp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_heater", 32'(heater), 32'd0);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_at", 32'(at_target), 32'd0);
    reset = 1'b1;

    // Full duty far below target, then proportional region
    enable = 1'b1; target = 12'sd200;
    @(negedge clk);
    strobe(100);
    chk("at_far", 32'(at_target), 32'd0);
    wait_duty(8'd255, "duty_full");
    count_heater(100, high);
    chk("heater_full_high", 32'(high), 32'd100);
    strobe(195);
    chk("duty_hold_midperiod", 32'(duty), 32'd255);
    wait_duty(8'd80, "duty_80");
    count_heater(512, high);
    chk("heater_80_steps", 32'(high), 32'd160);

    strobe(198);
    chk("at_198", 32'(at_target), 32'd1);
    strobe(210);
    chk("at_210", 32'(at_target), 32'd0);
    wait_duty(8'd0, "duty_overshoot");

    // Target above MAX_TEMP clamps to 280
    target = 12'sd400;
    strobe(270);
    wait_duty(8'd160, "duty_clamped");
    strobe(278);
    chk("at_clamped_278", 32'(at_target), 32'd1);
    strobe(277);
    chk("at_window_edge", 32'(at_target), 32'd1);
    strobe(276);
    chk("at_window_out", 32'(at_target), 32'd0);

    // Sensor sentinel high (also above MAX_TEMP: sensor has priority)
    strobe(300);
    chk("sens_fault", 32'(fault), 32'd1);
    chk("sens_code", 32'(fault_code), 32'd3);
    chk("sens_heater", 32'(heater), 32'd0);
    chk("sens_duty", 32'(duty), 32'd0);
    clear_fault();
    strobe(270);
    wait_duty(8'd160, "resume_duty");

    // Over-temperature
    target = 12'sd250;
    strobe(285);
    chk("ot_fault", 32'(fault), 32'd1);
    chk("ot_code", 32'(fault_code), 32'd1);
    clear_fault();

    // Fault condition coinciding with enable falling
    enable = 1'b0; temp = 12'sd285; temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    chk("simul_fault", 32'(fault), 32'd0);
    chk("simul_code", 32'(fault_code), 32'd0);
    chk("simul_duty", 32'(duty), 32'd0);
    enable = 1'b1;
    @(negedge clk);

    // Sensor sentinel low
    strobe(-55);
    chk("sens_lo_code", 32'(fault_code), 32'd3);
    clear_fault();

    // Asynchronous reset while heater is driven high
    target = 12'sd200;
    strobe(100);
    wait_duty(8'd255, "pre_reset_duty");
    chk("pre_reset_heater", 32'(heater), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_heater", 32'(heater), 32'd0);
    chk("async_rst_duty", 32'(duty), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);

    // Runaway: no temperature rise while at full duty
    strobe(50);
    wait_duty(8'd255, "runaway_duty");
    n = 0;
    while (fault !== 1'b1 && n < 6000) begin
      strobe(50);
      repeat (99) @(negedge clk);
      n += 100;
    end
    chk("runaway_time_ok", 32'(n >= 2000 && n <= 3300), 32'd1);
    chk("runaway_code", 32'(fault_code), 32'd2);
    chk("runaway_heater", 32'(heater), 32'd0);

    // Rising by RUNAWAY_DELTA every 2 s keeps the timer from expiring
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cur = 50;
    strobe(cur);
    wait_duty(8'd255, "rise_duty");
    for (int i = 0; i < 80; i++) begin
      if (i > 0 && i % 20 == 0) cur += 2;
      strobe(cur);
      repeat (99) @(negedge clk);
    end
    chk("rise_no_fault", 32'(fault), 32'd0);
    chk("rise_code", 32'(fault_code), 32'd0);
    chk("rise_duty_end", 32'(duty), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
